tensor_stream_loader: RTL and testbench
=======================================

Name: tensor_stream_loader

Overview:
Upstream feeder for the tensor compute kernel. Accepts a serial valid/ready stream of 32-bit elements and packs them into N-element tensors. Presents each completed tensor as one flat parallel bus with a valid/ready handshake. Ping-pong (two-bank) buffering lets the next tensor fill while the kernel holds the current one, sustaining one element per cycle.

Parameters:
DATA_W, 32, element width in bits
N_ELEM, 4, elements per tensor (≥2)
PAD_VAL, 0, value written to unfilled slots when a tensor is closed early by in_last

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  DATA_W  stream element
in_valid  in  1  in_data valid
in_last  in  1  marks final element of a tensor; qualified by in_valid
in_ready  out  1  loader can accept an element this cycle
tensor_out  out  N_ELEM*DATA_W  packed tensor; element k at bits [k*DATA_W +: DATA_W], element 0 = first received
tensor_valid  out  1  tensor_out holds a complete tensor
tensor_ready  in  1  kernel accepts tensor_out
tensor_padded  out  1  current tensor was closed early by in_last (qualified by tensor_valid)
tensor_count  out  16  number of tensors handed off (tensor_valid & tensor_ready), wraps at 2^16

Behaviour:
- Reset (reset=0, async): both banks EMPTY, fill pointer = bank0, read pointer = bank0, element index = 0.
  - Outputs in reset: in_ready=0, tensor_valid=0, tensor_padded=0, tensor_count=0, tensor_out=0.
  - in_ready rises the first cycle after reset deasserts.
- Per-bank state: EMPTY → FILLING (first element accepted) → FULL (Nth element or in_last accepted) → EMPTY (handoff).
- in_ready = (fill bank not FULL). It is a function of registered state only; no combinational path from in_valid or tensor_ready.
- Accept: in_valid & in_ready writes in_data to slot idx of the fill bank and increments idx.
- Tensor close: occurs when idx == N_ELEM-1, or when in_last is accepted, whichever comes first.
  - Slots idx+1..N_ELEM-1 are written with PAD_VAL.
  - padded flag = (close came from in_last with idx < N_ELEM-1).
  - Bank becomes FULL; idx resets to 0; fill pointer toggles.
- in_last on the Nth element: normal close, padded=0. The stream carries no more than N_ELEM elements per tensor; a new tensor starts automatically after N_ELEM.
- Output side:
  - tensor_valid = read bank FULL.
  - tensor_out and tensor_padded come from the read bank and are held stable while tensor_valid & !tensor_ready.
  - Handoff on tensor_valid & tensor_ready: read bank → EMPTY, read pointer toggles, tensor_count increments.
- Latency: closing element accepted at edge t → tensor_valid=1 after edge t (visible cycle t+1), if the read pointer is on that bank.
- Simultaneous events:
  - A close and a handoff in the same cycle are both honoured.
  - Back-to-back tensors with tensor_ready held high give zero bubble cycles on the input.
- Both banks FULL: in_ready=0 until a handoff. in_ready returns the cycle after the handoff edge.
- Reset mid-operation discards partial and full tensors without emitting them.
- Outputs are registered, apart from tensor_out and tensor_padded, which are a 2:1 mux of bank registers selected by the registered read pointer.

Decomposition:
- Shared package holds:
  - DATA_W and N_ELEM defaults.
  - Bank-state encoding: EMPTY, FILLING, FULL.
  - The element-slice helper used by both loader and kernel.
- One natural sub-module: tensor_bank. It holds one N_ELEM×DATA_W register array, write port (idx, data, pad-fill), state, and padded flag. It is instantiated twice; the top handles pointers, handshakes and the counter.

Test Plan:
1. Single tensor: stream 3,1,4,2 (last on 2), tensor_ready=1 → tensor_valid one cycle after the 2 is accepted; tensor_out elements = {3,1,4,2}; tensor_padded=0; tensor_count=1.
2. Early last: stream 7,9 with in_last on 9 → tensor_out = {7,9,0,0}; tensor_padded=1.
3. Backpressure: tensor_ready=0, stream 3 full tensors continuously.
   - in_ready drops after the 8th element; the 9th is held on the input.
   - Raise tensor_ready → tensors emitted in order, 9th accepted the cycle after the first handoff.
   - tensor_count=3 at end.
4. Full throughput: tensor_ready=1, in_valid=1 for 40 cycles with incrementing data → in_ready never deasserts after reset; 10 tensors {0..3},{4..7},…; tensor_count=10.
5. Reset mid-fill: accept 2 elements, pulse reset low asynchronously between edges.
   - All outputs are 0 immediately.
   - After release, stream 5,6,7,8 → output {5,6,7,8}; no stale data; tensor_count=1.
6. Count wrap: preload by streaming 65537 tensors → tensor_count=1.

Source files
------------

// File: rtl/tensor_stream_loader_pkg.sv
// Shared definitions for the tensor loader and the tensor compute kernel:
// default geometry, bank-state encoding and a packed-tensor element accessor.
package tensor_stream_loader_pkg;

  localparam int unsigned TSL_DATA_W = 32;
  localparam int unsigned TSL_N_ELEM = 4;

  typedef logic [1:0] bank_state_t;

  localparam bank_state_t BANK_EMPTY   = 2'd0;
  localparam bank_state_t BANK_FILLING = 2'd1;
  localparam bank_state_t BANK_FULL    = 2'd2;

  // Element k of a packed tensor; element 0 sits in the least-significant slice.
  function automatic logic [TSL_DATA_W-1:0] elem_slice(
    input logic [TSL_N_ELEM*TSL_DATA_W-1:0] t,
    input int unsigned                       k
  );
    return t[k*TSL_DATA_W +: TSL_DATA_W];
  endfunction

endpackage

// File: rtl/tensor_bank.sv
// One tensor buffer: N_ELEM element registers, fill state and padded flag.
// A closing write also pad-fills every slot above the written index.
module tensor_bank
  import tensor_stream_loader_pkg::*;
#(
  parameter  int unsigned          DATA_W  = TSL_DATA_W,
  parameter  int unsigned          N_ELEM  = TSL_N_ELEM,
  parameter  logic [DATA_W-1:0]    PAD_VAL = '0,
  localparam int unsigned          IDX_W   = $clog2(N_ELEM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_close,
  input  logic                       wr_padded,
  input  logic                       rd_clear,
  output bank_state_t                state_next,
  output logic                       padded,
  output logic [N_ELEM*DATA_W-1:0]   data
);

  logic [N_ELEM-1:0][DATA_W-1:0] data_q, data_d;
  bank_state_t                   state_q, state_d;
  logic                          padded_q, padded_d;

  always_comb begin
    data_d   = data_q;
    state_d  = state_q;
    padded_d = padded_q;
    if (rd_clear) begin
      state_d = BANK_EMPTY;
    end
    if (wr_en) begin
      for (int unsigned k = 0; k < N_ELEM; k++) begin
        if (IDX_W'(k) == wr_idx) begin
          data_d[k] = wr_data;
        end else if (wr_close && (IDX_W'(k) > wr_idx)) begin
          data_d[k] = PAD_VAL;
        end
      end
      state_d = wr_close ? BANK_FULL : BANK_FILLING;
      if (wr_close) begin
        padded_d = wr_padded;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      state_q  <= BANK_EMPTY;
      padded_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      state_q  <= state_d;
      padded_q <= padded_d;
    end
  end

  assign state_next = state_d;
  assign padded     = padded_q;
  assign data       = data_q;

endmodule

// File: rtl/tensor_stream_loader.sv
// Packs a serial element stream into N_ELEM-wide tensors through two
// ping-pong banks; the top owns fill/read pointers, handshakes and the counter.
module tensor_stream_loader
  import tensor_stream_loader_pkg::*;
#(
  parameter  int unsigned        DATA_W  = TSL_DATA_W,
  parameter  int unsigned        N_ELEM  = TSL_N_ELEM,
  parameter  logic [DATA_W-1:0]  PAD_VAL = '0,
  localparam int unsigned        IDX_W   = $clog2(N_ELEM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [N_ELEM*DATA_W-1:0]   tensor_out,
  output logic                       tensor_valid,
  input  logic                       tensor_ready,
  output logic                       tensor_padded,
  output logic [15:0]                tensor_count
);

  logic             fill_ptr_q, fill_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             valid_q, valid_d;

  logic accept, at_end, close, pad_close, handoff;

  bank_state_t                bank_state_nxt [2];
  logic                       bank_padded    [2];
  logic [N_ELEM*DATA_W-1:0]   bank_data      [2];

  assign accept    = in_valid && in_ready_q;
  assign at_end    = (idx_q == IDX_W'(N_ELEM-1));
  assign close     = accept && (at_end || in_last);
  assign pad_close = in_last && !at_end;
  assign handoff   = valid_q && tensor_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tensor_bank #(
      .DATA_W  (DATA_W),
      .N_ELEM  (N_ELEM),
      .PAD_VAL (PAD_VAL)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (accept && (fill_ptr_q == 1'(b))),
      .wr_idx     (idx_q),
      .wr_data    (in_data),
      .wr_close   (close),
      .wr_padded  (pad_close),
      .rd_clear   (handoff && (rd_ptr_q == 1'(b))),
      .state_next (bank_state_nxt[b]),
      .padded     (bank_padded[b]),
      .data       (bank_data[b])
    );
  end

  // Handshake outputs are registered from next-cycle bank state so they
  // carry no combinational path from in_valid or tensor_ready.
  always_comb begin
    fill_ptr_d = fill_ptr_q ^ close;
    rd_ptr_d   = rd_ptr_q ^ handoff;
    count_d    = count_q + 16'(handoff);
    idx_d      = idx_q;
    if (close) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d = idx_q + IDX_W'(1);
    end
    in_ready_d = (bank_state_nxt[fill_ptr_d] != BANK_FULL);
    valid_d    = (bank_state_nxt[rd_ptr_d] == BANK_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign tensor_valid  = valid_q;
  assign tensor_count  = count_q;
  assign tensor_out    = rd_ptr_q ? bank_data[1] : bank_data[0];
  assign tensor_padded = rd_ptr_q ? bank_padded[1] : bank_padded[0];

endmodule

// File: tb/tb_tensor_stream_loader.sv
// Directed self-checking bench for tensor_stream_loader (DATA_W=32, N_ELEM=4).
module tb_tensor_stream_loader;
  import tensor_stream_loader_pkg::*;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] tensor_out;
  logic         tensor_valid;
  logic         tensor_ready;
  logic         tensor_padded;
  logic [15:0]  tensor_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [127:0] q_data [$];
  logic         q_pad  [$];

  tensor_stream_loader #(
    .DATA_W  (32),
    .N_ELEM  (4),
    .PAD_VAL (32'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .tensor_out    (tensor_out),
    .tensor_valid  (tensor_valid),
    .tensor_ready  (tensor_ready),
    .tensor_padded (tensor_padded),
    .tensor_count  (tensor_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every handoff; inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (reset && tensor_valid && tensor_ready) begin
      q_data.push_back(tensor_out);
      q_pad.push_back(tensor_padded);
    end
  end

  function automatic logic [127:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      chk_cnt++;
      $display("FAIL push_timeout data=%0d in_ready stuck at %0b, want 1", d, in_ready);
    end
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) step();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (tensor_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", tensor_valid); else pass_cnt++;
    chk_cnt++; if (tensor_padded !== 1'b0) $display("FAIL rst_padded got %0b want 0", tensor_padded); else pass_cnt++;
    chk_cnt++; if (tensor_count !== 16'd0) $display("FAIL rst_count got %0d want 0", tensor_count); else pass_cnt++;
    chk_cnt++; if (tensor_out !== 128'd0) $display("FAIL rst_out got %h want 0", tensor_out); else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_release_ready got %0b want 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready_rise got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    tensor_ready = 1'b1;
    q_data.delete(); q_pad.delete();
    push(32'd3, 1'b0);
    push(32'd1, 1'b0);
    push(32'd4, 1'b0);
    push(32'd2, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk_cnt++; if (tensor_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", tensor_valid); else pass_cnt++;
    chk_cnt++; if (tensor_out !== pack4(32'd3, 32'd1, 32'd4, 32'd2)) $display("FAIL single_out got %h want %h", tensor_out, pack4(32'd3, 32'd1, 32'd4, 32'd2)); else pass_cnt++;
    chk_cnt++; if (elem_slice(tensor_out, 2) !== 32'd4) $display("FAIL single_elem2 got %0d want 4", elem_slice(tensor_out, 2)); else pass_cnt++;
    chk_cnt++; if (tensor_padded !== 1'b0) $display("FAIL single_padded got %0b want 0", tensor_padded); else pass_cnt++;
    step();
    chk_cnt++; if (tensor_count !== 16'd1) $display("FAIL single_count got %0d want 1", tensor_count); else pass_cnt++;
    chk_cnt++; if (tensor_valid !== 1'b0) $display("FAIL single_valid_drop got %0b want 0", tensor_valid); else pass_cnt++;
  endtask

  task automatic test_early_last();
    push(32'd7, 1'b0);
    push(32'd9, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk_cnt++; if (tensor_valid !== 1'b1) $display("FAIL early_valid got %0b want 1", tensor_valid); else pass_cnt++;
    chk_cnt++; if (tensor_out !== pack4(32'd7, 32'd9, 32'd0, 32'd0)) $display("FAIL early_out got %h want %h", tensor_out, pack4(32'd7, 32'd9, 32'd0, 32'd0)); else pass_cnt++;
    chk_cnt++; if (tensor_padded !== 1'b1) $display("FAIL early_padded got %0b want 1", tensor_padded); else pass_cnt++;
    step();
    chk_cnt++; if (tensor_count !== 16'd2) $display("FAIL early_count got %0d want 2", tensor_count); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    base = tensor_count;
    tensor_ready = 1'b0;
    q_data.delete(); q_pad.delete();
    for (int i = 0; i < 8; i++) push(32'(100 + i), 1'b0);
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_drop got %0b want 0", in_ready); else pass_cnt++;
    in_data = 32'd108; in_last = 1'b0; in_valid = 1'b1;
    repeat (3) step();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held got %0b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (tensor_out !== pack4(32'd100, 32'd101, 32'd102, 32'd103)) $display("FAIL bp_hold_out got %h want %h", tensor_out, pack4(32'd100, 32'd101, 32'd102, 32'd103)); else pass_cnt++;
    tensor_ready = 1'b1;
    step();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_return got %0b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (tensor_count !== base + 16'd1) $display("FAIL bp_first_handoff got %0d want %0d", tensor_count, base + 16'd1); else pass_cnt++;
    chk_cnt++; if (tensor_out !== pack4(32'd104, 32'd105, 32'd106, 32'd107)) $display("FAIL bp_second_out got %h want %h", tensor_out, pack4(32'd104, 32'd105, 32'd106, 32'd107)); else pass_cnt++;
    step();
    push(32'd109, 1'b0);
    push(32'd110, 1'b0);
    push(32'd111, 1'b0);
    drain();
    chk_cnt++; if (tensor_count !== base + 16'd3) $display("FAIL bp_count got %0d want %0d", tensor_count, base + 16'd3); else pass_cnt++;
    chk_cnt++;
    if (q_data.size() != 3) $display("FAIL bp_num_tensors got %0d want 3", q_data.size());
    else if (q_data[0] !== pack4(32'd100, 32'd101, 32'd102, 32'd103) ||
             q_data[1] !== pack4(32'd104, 32'd105, 32'd106, 32'd107) ||
             q_data[2] !== pack4(32'd108, 32'd109, 32'd110, 32'd111))
      $display("FAIL bp_order got %h,%h,%h want tensors 100..111 in order", q_data[0], q_data[1], q_data[2]);
    else pass_cnt++;
  endtask

  task automatic test_throughput();
    int drops;
    logic [15:0] base;
    logic ok;
    base = tensor_count;
    drops = 0;
    tensor_ready = 1'b1;
    q_data.delete(); q_pad.delete();
    for (int i = 0; i < 40; i++) begin
      in_data = 32'(i); in_last = 1'b0; in_valid = 1'b1;
      if (!in_ready) drops++;
      step();
    end
    drain();
    chk_cnt++; if (drops != 0) $display("FAIL tp_bubbles got %0d want 0", drops); else pass_cnt++;
    chk_cnt++; if (tensor_count !== base + 16'd10) $display("FAIL tp_count got %0d want %0d", tensor_count, base + 16'd10); else pass_cnt++;
    ok = (q_data.size() == 10);
    for (int t = 0; t < q_data.size() && t < 10; t++) begin
      if (q_data[t] !== pack4(32'(4*t), 32'(4*t+1), 32'(4*t+2), 32'(4*t+3)) || q_pad[t] !== 1'b0) ok = 1'b0;
    end
    chk_cnt++; if (!ok) $display("FAIL tp_tensors got %0d tensors, want 10 of {4t..4t+3} unpadded", q_data.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    push(32'd55, 1'b0);
    push(32'd66, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready got %0b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (tensor_count !== 16'd0) $display("FAIL mid_rst_count got %0d want 0", tensor_count); else pass_cnt++;
    chk_cnt++; if (tensor_out !== 128'd0 || tensor_valid !== 1'b0 || tensor_padded !== 1'b0)
      $display("FAIL mid_rst_outs got out=%h valid=%0b padded=%0b want all 0", tensor_out, tensor_valid, tensor_padded);
    else pass_cnt++;
    step();
    #2 reset = 1'b1;
    step();
    q_data.delete(); q_pad.delete();
    push(32'd5, 1'b0);
    push(32'd6, 1'b0);
    push(32'd7, 1'b0);
    push(32'd8, 1'b1);
    drain();
    chk_cnt++; if (tensor_count !== 16'd1) $display("FAIL mid_count got %0d want 1", tensor_count); else pass_cnt++;
    chk_cnt++;
    if (q_data.size() != 1 || q_data[0] !== pack4(32'd5, 32'd6, 32'd7, 32'd8))
      $display("FAIL mid_out got %0d tensors first=%h want 1 tensor %h", q_data.size(), (q_data.size() > 0) ? q_data[0] : 128'd0, pack4(32'd5, 32'd6, 32'd7, 32'd8));
    else pass_cnt++;
  endtask

  task automatic test_count_wrap();
    int drops;
    drops = 0;
    #2 reset = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    tensor_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = 32'(i); in_last = 1'b1; in_valid = 1'b1;
      if (!in_ready) drops++;
      step();
    end
    drain();
    q_data.delete(); q_pad.delete();
    chk_cnt++; if (drops != 0) $display("FAIL wrap_bubbles got %0d want 0", drops); else pass_cnt++;
    chk_cnt++; if (tensor_count !== 16'd0) $display("FAIL wrap_count_zero got %0d want 0", tensor_count); else pass_cnt++;
    push(32'd65536, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk_cnt++; if (tensor_out !== pack4(32'd65536, 32'd0, 32'd0, 32'd0) || tensor_padded !== 1'b1)
      $display("FAIL wrap_last_out got %h padded=%0b want %h padded=1", tensor_out, tensor_padded, pack4(32'd65536, 32'd0, 32'd0, 32'd0));
    else pass_cnt++;
    drain();
    chk_cnt++; if (tensor_count !== 16'd1) $display("FAIL wrap_count got %0d want 1", tensor_count); else pass_cnt++;
  endtask

  initial begin
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    tensor_ready = 1'b0;
    test_reset();
    test_single();
    test_early_last();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_count_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
